// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the datapath sequencer (master) and mul_div_unit (slave).
// No backpressure: start is a request pulse, done a one-cycle result strobe.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result_hi, result_lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result_hi, result_lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_addsub.sv
// Combinational W-bit adder/subtractor shared by the Booth step and the restoring trial subtract.
// Zero latency, no handshake.
module muldiv_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic         i_sub,
    output logic [W-1:0] o_sum
);
    assign o_sum = i_sub ? (i_x - i_y) : (i_x + i_y);
endmodule

// File: rtl/mul_div_unit.sv
// Signed Booth multiply / restoring divide, one bit per clock: 33-cycle latency, 1 for DIV by zero or DIV
// without MULDIV_DIV_EN (which compiles in the divider). start is ignored unless idle; done is a 1-cycle pulse.
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          Clock,
    input  logic          clear,
    mul_div_unit_if.slave mdu
);
    localparam cnt_t CNT_LAST = cnt_t'(ITER_COUNT - 1);

    state_t           r_state;
    state_t           w_next_state;
    cnt_t             r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_short;
    logic             r_op;
    logic             r_q1;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_res_hi;
    logic [WIDTH-1:0] r_res_lo;

    logic             w_accept;
    logic             w_short;
    logic             w_booth_add;
    logic             w_sub;
    logic [WIDTH:0]   w_x;
    logic [WIDTH:0]   w_y;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_step;
    logic [WIDTH-1:0] w_fin_hi;
    logic [WIDTH-1:0] w_fin_lo;

`ifdef MULDIV_DIV_EN
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dbz;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    assign w_short = (mdu.op == OP_DIV) && (mdu.b == '0);
    assign w_abs_a = mdu.a[WIDTH-1] ? -mdu.a : mdu.a;
    assign w_abs_b = mdu.b[WIDTH-1] ? -mdu.b : mdu.b;
`else
    assign w_short = (mdu.op == OP_DIV);
`endif

    // Short ops (no iterations) wait one cycle in IDLE with busy set, then jump straight to DONE.
    assign w_accept    = (r_state == IDLE) && !r_busy && mdu.start;
    assign w_booth_add = (r_lo[0] != r_q1);

    always_comb begin
        w_x   = {r_hi[WIDTH-1], r_hi};
        w_y   = {r_opa[WIDTH-1], r_opa};
        w_sub = r_lo[0] & ~r_q1;
`ifdef MULDIV_DIV_EN
        if (r_op == OP_DIV) begin
            w_x   = {r_hi, r_lo[WIDTH-1]};
            w_y   = {1'b0, r_opa};
            w_sub = 1'b1;
        end
`endif
    end

    muldiv_addsub #(.W(WIDTH + 1)) u_addsub (
        .i_x   (w_x),
        .i_y   (w_y),
        .i_sub (w_sub),
        .o_sum (w_sum)
    );

    assign w_step = w_booth_add ? w_sum : w_x;

    always_comb begin
        w_fin_hi = r_hi;
        w_fin_lo = r_lo;
`ifdef MULDIV_DIV_EN
        if ((r_state == FIX) && (r_op == OP_DIV)) begin
            if (r_neg_r) w_fin_hi = -r_hi;
            if (r_neg_q) w_fin_lo = -r_lo;
        end
`endif
    end

    always_ff @(posedge Clock) begin
        if (!clear) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (r_short)                    w_next_state = DONE;
                else if (w_accept && !w_short)  w_next_state = RUN;
            end
            RUN:     if (r_cnt == CNT_LAST) w_next_state = FIX;
            FIX:     w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!clear) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_short  <= 1'b0;
            r_cnt    <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
        end else begin
            r_done  <= (w_next_state == DONE);
            r_short <= w_accept && w_short;
            if (w_accept)              r_busy <= 1'b1;
            else if (r_state == DONE)  r_busy <= 1'b0;
            if (w_accept)              r_cnt <= '0;
            else if (r_state == RUN)   r_cnt <= r_cnt + cnt_t'(1);
            if (w_next_state == DONE) begin
                r_res_hi <= w_fin_hi;
                r_res_lo <= w_fin_lo;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!clear) begin
            r_op  <= OP_MUL;
            r_q1  <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_opa <= '0;
`ifdef MULDIV_DIV_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else if (w_accept) begin
            r_op <= mdu.op;
            r_q1 <= 1'b0;
            if (mdu.op == OP_MUL) begin
                r_opa <= mdu.a;
                r_hi  <= '0;
                r_lo  <= mdu.b;
            end else begin
`ifdef MULDIV_DIV_EN
                r_neg_q <= mdu.a[WIDTH-1] ^ mdu.b[WIDTH-1];
                r_neg_r <= mdu.a[WIDTH-1];
                r_opa   <= w_abs_b;
                r_hi    <= w_short ? mdu.a : '0;
                r_lo    <= w_short ? '1 : w_abs_a;
`else
                r_opa <= '0;
                r_hi  <= '0;
                r_lo  <= '0;
`endif
            end
        end else if (r_state == RUN) begin
            if (r_op == OP_MUL) begin
                r_hi <= w_step[WIDTH:1];
                r_lo <= {w_step[0], r_lo[WIDTH-1:1]};
                r_q1 <= r_lo[0];
            end else begin
`ifdef MULDIV_DIV_EN
                // A set sign bit on the trial difference means |b| did not fit: keep the shifted remainder.
                r_hi <= w_sum[WIDTH] ? w_x[WIDTH-1:0] : w_sum[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], ~w_sum[WIDTH]};
`endif
            end
        end
    end

`ifdef MULDIV_DIV_EN
    always_ff @(posedge Clock) begin
        if (!clear)        r_dbz <= 1'b0;
        else if (w_accept) r_dbz <= 1'b0;
        else if (r_short)  r_dbz <= 1'b1;
    end

    assign mdu.div_by_zero = r_dbz;
`else
    assign mdu.div_by_zero = 1'b0;
`endif

    assign mdu.busy      = r_busy;
    assign mdu.done      = r_done;
    assign mdu.result_hi = r_res_hi;
    assign mdu.result_lo = r_res_lo;

endmodule
